// File: rtl/aes_uart_pkg.sv
// Shared types and sizing for the UART-fed AES frame assembler.
package aes_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  localparam int FRAME_BYTES          = 32;
  localparam int KEY_BYTES            = 16;
  localparam int DEFAULT_CLKS_PER_BIT = 87;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 serial receiver: synchronizes the line, samples mid-bit, and strobes each byte.
// state    | meaning
// ST_IDLE  | line idle, waiting for a synchronized high-to-low edge
// ST_START | half-bit wait, then confirm start bit is still low
// ST_DATA  | sample 8 data bits, LSB first, one per bit period
// ST_STOP  | sample stop bit; high = byte strobe, low = stop error
module uart_rx_byte
  import aes_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] byte_data,
  output logic       byte_strobe,
  output logic       stop_err,
  output logic       rx_idle
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_e        state, state_nxt;
  logic             rx_meta, rx_sync, rx_q;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             tc, fell;

  assign tc        = (cnt == '0);
  assign fell      = rx_q & ~rx_sync;
  assign byte_data = shift_reg;

  // Synchronizer and edge-detect history all idle high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_q    <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_q    <= rx_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (fell) state_nxt = ST_START;
      ST_START: if (tc) state_nxt = rx_sync ? ST_IDLE : ST_DATA;
      ST_DATA:  if (tc && bit_idx == 3'd7) state_nxt = ST_STOP;
      ST_STOP:  if (tc) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    byte_strobe = (state == ST_STOP) && tc && rx_sync;
    stop_err    = (state == ST_STOP) && tc && !rx_sync;
    rx_idle     = (state == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt     <= HALF_LOAD;
          bit_idx <= '0;
        end
        ST_START: cnt <= tc ? BIT_LOAD : cnt - 1'b1;
        ST_DATA: begin
          if (tc) begin
            cnt       <= BIT_LOAD;
            shift_reg <= {rx_sync, shift_reg[7:1]};
            bit_idx   <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_STOP: if (!tc) cnt <= cnt - 1'b1;
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: rtl/aes_uart_rx_framer.sv
// Collects 32 UART bytes into an AES key + plaintext block and hands it off with a valid/ready pair.
module aes_uart_rx_framer
  import aes_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         uart_rx,
  input  logic         frame_ready,
  output logic [127:0] key,
  output logic [127:0] plaintext,
  output logic         frame_valid,
  output logic [7:0]   frame_count,
  output logic         framing_error,
  output logic         overrun
);

  localparam int TO_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W    = $clog2(TO_CLKS + 1);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TO_CLKS - 1);
  localparam int BUF_W   = FRAME_BYTES * 8;
  localparam int KEY_W   = KEY_BYTES * 8;

  logic [7:0]       byte_data;
  logic             byte_strobe, stop_err, rx_idle;
  logic [4:0]       idx;
  logic [BUF_W-1:0] asm_buf;
  logic [TO_W-1:0]  to_cnt;
  logic             accept, frame_done, to_expire;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk         (clk),
    .reset       (reset),
    .uart_rx     (uart_rx),
    .byte_data   (byte_data),
    .byte_strobe (byte_strobe),
    .stop_err    (stop_err),
    .rx_idle     (rx_idle)
  );

  assign accept     = frame_valid & frame_ready;
  assign frame_done = byte_strobe & (idx == 5'(FRAME_BYTES - 1));
  assign to_expire  = rx_idle & (idx != '0) & (to_cnt == '0);

  // Idle timer only runs while a partial frame is pending and the receiver is idle.
  always_ff @(posedge clk) begin
    if (reset)                        to_cnt <= TO_LOAD;
    else if (!rx_idle || idx == '0)   to_cnt <= TO_LOAD;
    else if (to_cnt != '0)            to_cnt <= to_cnt - 1'b1;
  end

  // Byte i lands at bit offset (31-i)*8, i.e. {~i, 3'b000}; the index wraps 31 -> 0 naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx     <= '0;
      asm_buf <= '0;
    end else if (stop_err) begin
      idx <= '0;
    end else if (byte_strobe) begin
      asm_buf[{~idx, 3'b000} +: 8] <= byte_data;
      idx                          <= idx + 5'd1;
    end else if (to_expire) begin
      idx <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key           <= '0;
      plaintext     <= '0;
      frame_valid   <= 1'b0;
      frame_count   <= '0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (stop_err) framing_error <= 1'b1;
      if (accept) begin
        frame_valid <= 1'b0;
        frame_count <= frame_count + 8'd1;
      end
      // Last byte bypasses the buffer so the copy happens on its own strobe.
      if (frame_done) begin
        if (!frame_valid || accept) begin
          key         <= asm_buf[BUF_W-1 -: KEY_W];
          plaintext   <= {asm_buf[BUF_W-KEY_W-1:8], byte_data};
          frame_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_uart_rx_framer.sv
// Randomized bench for aes_uart_rx_framer against a byte-level frame model.
module tb_aes_uart_rx_framer;

  localparam int CPB = 16;
  localparam int TOB = 4;

  logic         clk = 1'b0;
  logic         reset, uart_rx, frame_ready;
  logic [127:0] key, plaintext;
  logic         frame_valid, framing_error, overrun;
  logic [7:0]   frame_count;

  int total = 0;
  int bad   = 0;

  logic [7:0]   m_q[$];
  logic [127:0] m_key, m_pt;
  logic         m_valid, m_ferr, m_ovr;
  logic [7:0]   m_count;

  aes_uart_rx_framer #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clk           (clk),
    .reset         (reset),
    .uart_rx       (uart_rx),
    .frame_ready   (frame_ready),
    .key           (key),
    .plaintext     (plaintext),
    .frame_valid   (frame_valid),
    .frame_count   (frame_count),
    .framing_error (framing_error),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_reset();
    m_q.delete();
    m_key   = '0;
    m_pt    = '0;
    m_valid = 1'b0;
    m_ferr  = 1'b0;
    m_ovr   = 1'b0;
    m_count = '0;
  endtask

  task automatic m_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      m_q.delete();
      m_ferr = 1'b1;
      return;
    end
    m_q.push_back(b);
    if (m_q.size() == 32) begin
      if (m_valid) m_ovr = 1'b1;
      else begin
        for (int i = 0; i < 16; i++) begin
          m_key[127-8*i -: 8] = m_q[i];
          m_pt[127-8*i -: 8]  = m_q[16+i];
        end
        m_valid = 1'b1;
      end
      m_q.delete();
    end
  endtask

  task automatic m_accept();
    if (m_valid) begin
      m_valid = 1'b0;
      m_count = m_count + 8'd1;
    end
  endtask

  task automatic tx_byte(input logic [7:0] b, input bit ok);
    @(negedge clk);
    uart_rx = 1'b0;
    clks(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      clks(CPB);
    end
    uart_rx = ok;
    clks(CPB);
    if (!ok) begin
      uart_rx = 1'b1;
      clks(CPB);
    end
    uart_rx = 1'b1;
    m_byte(b, ok);
  endtask

  task automatic send_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      tx_byte(8'($urandom_range(0, 255)), 1'b1);
      clks(int'($urandom_range(0, CPB - 1)));
    end
  endtask

  task automatic accept_pulse();
    @(negedge clk);
    frame_ready = 1'b1;
    clks(1);
    frame_ready = 1'b0;
    m_accept();
  endtask

  task automatic check_all(input string pfx);
    chk({pfx, "_key"},   key,                   m_key);
    chk({pfx, "_pt"},    plaintext,             m_pt);
    chk({pfx, "_valid"}, 128'(frame_valid),     128'(m_valid));
    chk({pfx, "_count"}, 128'(frame_count),     128'(m_count));
    chk({pfx, "_ferr"},  128'(framing_error),   128'(m_ferr));
    chk({pfx, "_ovr"},   128'(overrun),         128'(m_ovr));
  endtask

  initial begin
    uart_rx     = 1'b1;
    frame_ready = 1'b0;
    reset       = 1'b1;
    m_reset();
    clks(3);
    reset = 1'b0;
    clks(2);
    check_all("rst");

    for (int i = 0; i < 31; i++) tx_byte(8'(i), 1'b1);
    chk("seq_valid_b30", 128'(frame_valid), 128'd0);
    tx_byte(8'd31, 1'b1);
    check_all("seq");
    chk("seq_key_lit", key,       128'h000102030405060708090a0b0c0d0e0f);
    chk("seq_pt_lit",  plaintext, 128'h101112131415161718191a1b1c1d1e1f);

    accept_pulse();
    check_all("acc");
    @(negedge clk);
    frame_ready = 1'b1;
    clks(5);
    frame_ready = 1'b0;
    chk("hold_count", 128'(frame_count), 128'd1);
    check_all("hold");

    send_bytes(3);
    tx_byte(8'hA5, 1'b0);
    check_all("ferr");
    send_bytes(32);
    check_all("ferr_frame");
    accept_pulse();

    for (int f = 0; f < 2; f++) begin
      send_bytes(32);
      check_all("rnd");
      accept_pulse();
      check_all("rnd_acc");
    end

    send_bytes(32);
    send_bytes(32);
    check_all("ovr");
    accept_pulse();

    send_bytes(10);
    clks(TOB * CPB);
    m_q.delete();
    send_bytes(32);
    check_all("tmo");
    accept_pulse();

    send_bytes(5);
    @(negedge clk);
    uart_rx = 1'b0;
    clks(3);
    uart_rx = 1'b1;
    clks(2 * CPB);
    send_bytes(27);
    check_all("glitch");

    send_bytes(20);
    @(negedge clk);
    uart_rx = 1'b0;
    clks(CPB);
    uart_rx = 1'b1;
    clks(3 * CPB);
    reset = 1'b1;
    clks(2);
    reset = 1'b0;
    m_reset();
    clks(2);
    check_all("midrst");

    send_bytes(32);
    check_all("resume");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_uart_rx_framer.md
AES_UART_RX_FRAMER -- requirements
Module: aes_uart_rx_framer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, clocks per UART bit period (10 MHz / 115200).
REQ-002 SHALL have parameter TIMEOUT_BITS, default 32, idle bit periods mid-frame before assembly aborts.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port uart_rx  input  1  asynchronous serial line, 8N1, idle high.
REQ-006 SHALL have port frame_ready  input  1  downstream AES core accepts the presented frame.
REQ-007 SHALL have port key  output  128  assembled key, byte 0 in [127:120].
REQ-008 SHALL have port plaintext  output  128  assembled data block, byte 16 in [127:120].
REQ-009 SHALL have port frame_valid  output  1  key/plaintext hold a complete, unaccepted frame.
REQ-010 SHALL have port frame_count  output  8  number of frames accepted downstream, wraps 255->0.
REQ-011 SHALL have port framing_error  output  1  sticky: stop bit sampled low since reset.
REQ-012 SHALL have port overrun  output  1  sticky: frame completed while frame_valid still high.

Function
REQ-013 SHALL pass uart_rx through a 2-flop synchronizer; both flops reset to 1.
REQ-014 SHALL implement a receive FSM with states IDLE, START, DATA, STOP.
REQ-015 IDLE->START on synchronized falling edge (high to low).
REQ-016 START SHALL wait CLKS_PER_BIT/2 clocks, then go to DATA if line low, else to IDLE (glitch reject).
REQ-017 DATA SHALL sample every CLKS_PER_BIT clocks, 8 samples, LSB first, then go to STOP.
REQ-018 STOP SHALL sample once after CLKS_PER_BIT clocks, then return to IDLE in the next cycle.
REQ-019 A high stop sample SHALL produce a one-cycle internal byte strobe; a low stop sample SHALL discard the byte, set framing_error, and clear the byte index to 0.
REQ-020 SHALL maintain a 5-bit byte index into a 32-byte assembly buffer; bytes 0-15 are key, bytes 16-31 plaintext, MSB-first placement.
REQ-021 On the strobe for byte 31, the buffer SHALL copy into key/plaintext and frame_valid SHALL rise on the next edge; the index wraps to 0.
REQ-022 If frame_valid is high when byte 31 completes, the output registers SHALL NOT change, overrun SHALL set, and the new frame is dropped.
REQ-023 Acceptance SHALL occur on a cycle with frame_valid and frame_ready both high; frame_valid clears and frame_count increments on that edge.
REQ-024 Acceptance and byte 31 completion in the same cycle SHALL load the new frame, keep frame_valid high, increment frame_count, and leave overrun unchanged.
REQ-025 key/plaintext SHALL stay stable while frame_valid is high.
REQ-026 When the index is nonzero and the FSM stays in IDLE for TIMEOUT_BITS*CLKS_PER_BIT clocks, the index SHALL clear to 0 (partial frame dropped, no flag).
REQ-027 frame_ready while frame_valid is low SHALL have no effect.

Reset
REQ-028 Reset SHALL put the FSM in IDLE and clear the index, the bit counter and the timeout counter.
REQ-029 Reset SHALL set key=0, plaintext=0, frame_valid=0, frame_count=0, framing_error=0 and overrun=0.
REQ-030 Reset mid-byte or mid-frame SHALL discard all partial data; reception resumes on the next falling edge after reset deasserts.

Structure
REQ-031 Package aes_uart_pkg SHALL hold:
- the FSM state enum;
- FRAME_BYTES=32 and KEY_BYTES=16;
- the default CLKS_PER_BIT.
REQ-032 Serial-to-byte logic (REQ-013..019) SHALL be the sub-module uart_rx_byte with outputs byte_data[7:0], byte_strobe and stop_err.
REQ-033 Frame assembly, handshake and counters SHALL reside in aes_uart_rx_framer.

Verification (CLKS_PER_BIT=16, TIMEOUT_BITS=4)
REQ-034 Send bytes 0x00..0x0F then 0x10..0x1F, frame_ready=0 -> key=0x000102...0F, plaintext=0x101112...1F, frame_valid=1 one edge after byte 31 stop sample.
REQ-035 Raise frame_ready for 1 cycle -> frame_valid=0 and frame_count=1; frame_ready held for 5 further cycles -> frame_count stays 1.
REQ-036 Send byte 0xA5 with stop bit low at index 3 -> framing_error=1 and index=0; the next 32 good bytes form a correct frame.
REQ-037 Send 32 bytes twice with frame_ready=0 -> overrun=1 and key/plaintext still hold the first frame.
REQ-038 Send 10 bytes, then 4 idle bit periods, then 32 bytes -> the frame contains only the last 32 bytes.
REQ-039 Apply a 3-clock low glitch on uart_rx -> no byte strobe; apply reset during byte 20 -> all outputs return to reset values.
